// File: rtl/image_op_sequencer_pkg.sv
// Shared definitions for the image operation sequencer: mode encodings,
// controller state encoding and the mode-to-select decode.
package image_pkg;

  localparam logic [2:0] MODE_PASS = 3'd0;
  localparam logic [2:0] MODE_INC  = 3'd1;
  localparam logic [2:0] MODE_DEC  = 3'd2;
  localparam logic [2:0] MODE_INV  = 3'd3;
  localparam logic [2:0] MODE_THR  = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    RESTART,
    WAIT_START,
    RUN,
    GAP
  } state_t;

  // One-hot reader select, bit order {thr, inv, dec, inc}.
  function automatic logic [3:0] mode_to_sel(input logic [2:0] mode);
    logic [3:0] sel;
    sel = 4'b0000;
    case (mode)
      MODE_INC: sel = 4'b0001;
      MODE_DEC: sel = 4'b0010;
      MODE_INV: sel = 4'b0100;
      MODE_THR: sel = 4'b1000;
      default:  sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/image_op_sequencer_if.sv
// Control/status link between the sequencer (master) and the image reader.
interface image_op_sequencer_if;
  logic reader_rst_n;
  logic sel_inc;
  logic sel_dec;
  logic sel_inv;
  logic sel_thr;
  logic rd_started;
  logic rd_done;

  modport master (
    output reader_rst_n, sel_inc, sel_dec, sel_inv, sel_thr,
    input  rd_started, rd_done
  );

  modport slave (
    input  reader_rst_n, sel_inc, sel_dec, sel_inv, sel_thr,
    output rd_started, rd_done
  );
endinterface

// File: rtl/image_op_sequencer_btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          prev_reg;
  logic          accepted_reg;
  logic [CW-1:0] cnt_reg;

  // Synchronise, restart the counter on any level change, accept a level
  // once it has been stable long enough and pulse on an accepted rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      prev_reg     <= 1'b0;
      accepted_reg <= 1'b0;
      cnt_reg      <= '0;
      press        <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      press     <= 1'b0;
      if (sync2_reg != prev_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        accepted_reg <= sync2_reg;
        press        <= sync2_reg & ~accepted_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_op_sequencer.sv
// Frame-level controller for the image reader: latches debounced operation
// requests, restarts the reader once per frame with the requested mode,
// counts completed frames and flags reader hangs.
module image_op_sequencer
  import image_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESTART_CYCLES  = 4,
  parameter int GAP_CYCLES      = 8,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   enable,
  input  logic                   btn_inc,
  input  logic                   btn_dec,
  input  logic                   btn_inv,
  input  logic                   btn_thr,
  image_op_sequencer_if.master   rd,
  output logic [2:0]             op_mode,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   wd_error
);

  localparam int CNT_W    = 16;
  localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  logic [3:0]      btn_vec;
  logic [3:0]      press;
  logic            press_any;
  logic [2:0]      press_mode;
  logic [2:0]      req_mode;
  logic            wd_timeout;
  logic            go_restart;

  state_t          state_reg;
  logic            reader_rst_n_reg;
  logic [3:0]      sel_reg;
  logic            pending_valid_reg;
  logic [2:0]      pending_mode_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WD_W-1:0] wd_cnt_reg;

  assign btn_vec = {btn_thr, btn_inv, btn_dec, btn_inc};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (HCLK),
        .rst   (HRESET),
        .btn   (btn_vec[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  // Resolve simultaneous presses (inc > dec > inv > thr); pressing the mode
  // already applied requests pass-through instead.
  always_comb begin
    press_any  = |press;
    press_mode = MODE_PASS;
    if (press[0])      press_mode = MODE_INC;
    else if (press[1]) press_mode = MODE_DEC;
    else if (press[2]) press_mode = MODE_INV;
    else if (press[3]) press_mode = MODE_THR;
    req_mode = (press_mode == op_mode) ? MODE_PASS : press_mode;
  end

  // Frame-boundary conditions that lead into RESTART.
  always_comb begin
    wd_timeout = ((state_reg == WAIT_START) || (state_reg == RUN)) &&
                 (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
    go_restart = ((state_reg == IDLE) && enable) ||
                 ((state_reg == GAP) && (cnt_reg == CNT_W'(GAP_LAST)) && enable) ||
                 wd_timeout;
  end

  // Frame sequencing FSM with pending-request latch, frame counter and watchdog.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg         <= IDLE;
      reader_rst_n_reg  <= 1'b0;
      sel_reg           <= 4'b0000;
      op_mode           <= MODE_PASS;
      frame_count       <= '0;
      wd_error          <= 1'b0;
      pending_valid_reg <= 1'b0;
      pending_mode_reg  <= MODE_PASS;
      cnt_reg           <= '0;
      wd_cnt_reg        <= '0;
    end else begin
      if (press_any) begin
        pending_valid_reg <= 1'b1;
        pending_mode_reg  <= req_mode;
      end

      case (state_reg)
        IDLE: begin
          reader_rst_n_reg <= 1'b0;
        end
        RESTART: begin
          if (cnt_reg == CNT_W'(RESTART_CYCLES - 1)) begin
            state_reg        <= WAIT_START;
            reader_rst_n_reg <= 1'b1;
            wd_cnt_reg       <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_START: begin
          wd_cnt_reg <= wd_cnt_reg + 1'b1;
          if (rd.rd_started) state_reg <= RUN;
        end
        RUN: begin
          wd_cnt_reg <= wd_cnt_reg + 1'b1;
          if (rd.rd_done && !wd_timeout) begin
            frame_count <= frame_count + 1'b1;
            state_reg   <= GAP;
            cnt_reg     <= '0;
          end
        end
        GAP: begin
          if (cnt_reg == CNT_W'(GAP_LAST)) begin
            state_reg        <= IDLE;
            reader_rst_n_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg        <= IDLE;
          reader_rst_n_reg <= 1'b0;
        end
      endcase

      // Entering RESTART is the only point where the applied mode changes;
      // op_mode and its select decode update together so the selects are
      // settled for the whole reset window.
      if (go_restart) begin
        state_reg        <= RESTART;
        reader_rst_n_reg <= 1'b0;
        cnt_reg          <= '0;
        if (pending_valid_reg) begin
          op_mode <= pending_mode_reg;
          sel_reg <= mode_to_sel(pending_mode_reg);
        end
        if (!press_any) pending_valid_reg <= 1'b0;
      end

      if (wd_timeout) wd_error <= 1'b1;
    end
  end

  assign busy            = (state_reg != IDLE);
  assign rd.reader_rst_n = reader_rst_n_reg;
  assign rd.sel_inc      = sel_reg[0];
  assign rd.sel_dec      = sel_reg[1];
  assign rd.sel_inv      = sel_reg[2];
  assign rd.sel_thr      = sel_reg[3];

endmodule
